// File: rtl/coef_stream_pkg.sv
// Shared definitions for the coefficient stream packer/unpacker pair:
// word field layout, row geometry, plane encoding and tag layout.
package coef_stream_pkg;

  localparam int unsigned COEF_PACK_W    = 12;
  localparam int unsigned COEF_A_LSB     = 0;
  localparam int unsigned COEF_B_LSB     = 12;
  localparam int unsigned TAG_LSB        = 24;
  localparam int unsigned TAG_W          = 8;
  localparam int unsigned WORDS_PER_ROW  = 4;
  localparam int unsigned ROWS_PER_BLOCK = 8;
  localparam int unsigned COLS_PER_ROW   = 8;

  typedef enum logic [1:0] {
    PLANE_Y  = 2'd0,
    PLANE_CB = 2'd1,
    PLANE_CR = 2'd2
  } plane_e;

  // Tag byte: [7:5] reserved (zero), [4:2] row, [1:0] plane
  typedef struct packed {
    logic [2:0] rsvd;
    logic [2:0] row;
    logic [1:0] plane;
  } tag_t;

  typedef enum logic {
    ROW_EMPTY = 1'b0,
    ROW_FULL  = 1'b1
  } row_state_e;

  function automatic tag_t expected_tag(input logic [2:0] row, input logic [1:0] plane);
    tag_t t;
    t.rsvd  = 3'b000;
    t.row   = row;
    t.plane = plane;
    return t;
  endfunction

endpackage

// File: rtl/coef_row_reg.sv
// Single-entry output register for one coefficient row with valid/ready handshake.
module coef_row_reg
  import coef_stream_pkg::*;
#(
  parameter int unsigned COEF_W = 12
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic                                i_load,
  input  logic [COLS_PER_ROW-1:0][COEF_W-1:0] i_data,
  input  logic [1:0]                          i_plane,
  input  logic [2:0]                          i_row,
  input  logic                                i_ready,
  output logic                                o_valid,
  output logic [COLS_PER_ROW-1:0][COEF_W-1:0] o_data,
  output logic [1:0]                          o_plane,
  output logic [2:0]                          o_row
);

  row_state_e r_state;

  // EMPTY/FULL state plus row payload; a load always wins over a consume
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ROW_EMPTY;
      o_data  <= '0;
      o_plane <= 2'd0;
      o_row   <= 3'd0;
    end else begin
      if (i_load) begin
        o_data  <= i_data;
        o_plane <= i_plane;
        o_row   <= i_row;
      end
      case (r_state)
        ROW_EMPTY: if (i_load) r_state <= ROW_FULL;
        ROW_FULL:  if (i_ready && !i_load) r_state <= ROW_EMPTY;
        default:   r_state <= ROW_EMPTY;
      endcase
    end
  end

  assign o_valid = (r_state == ROW_FULL);

endmodule

// File: rtl/coef_stream_unpacker.sv
// Rebuilds 8-coefficient rows of Y/Cb/Cr 8x8 blocks from the packed 32-bit
// coefficient stream. Optional tag checking is enabled by defining TAG_CHECK_EN.
module coef_stream_unpacker
  import coef_stream_pkg::*;
#(
  parameter int unsigned COEF_W     = 12,
  parameter int unsigned NUM_PLANES = 3
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [31:0]       s_axis_data,
  input  logic              s_axis_valid,
  output logic              s_axis_ready,
  output logic [COEF_W-1:0] o_data0,
  output logic [COEF_W-1:0] o_data1,
  output logic [COEF_W-1:0] o_data2,
  output logic [COEF_W-1:0] o_data3,
  output logic [COEF_W-1:0] o_data4,
  output logic [COEF_W-1:0] o_data5,
  output logic [COEF_W-1:0] o_data6,
  output logic [COEF_W-1:0] o_data7,
  output logic [1:0]        o_plane,
  output logic [2:0]        o_row,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_intr,
  output logic              o_tag_err
);

  localparam logic [1:0] LAST_WORD  = 2'(WORDS_PER_ROW - 1);
  localparam logic [2:0] LAST_ROW   = 3'(ROWS_PER_BLOCK - 1);
  localparam logic [1:0] LAST_PLANE = 2'(NUM_PLANES - 1);

  logic [1:0]                          r_wcnt;
  logic [2:0]                          r_row;
  logic [1:0]                          r_plane;
  logic [COLS_PER_ROW-3:0][COEF_PACK_W-1:0] r_hold;
  logic                                r_intr;

  logic [COEF_PACK_W-1:0]              w_coef_a;
  logic [COEF_PACK_W-1:0]              w_coef_b;
  logic                                w_accept;
  logic                                w_load;
  logic                                w_full;
  logic                                w_consume;
  logic [COLS_PER_ROW-1:0][COEF_W-1:0] w_row_data;
  logic [COLS_PER_ROW-1:0][COEF_W-1:0] w_out_data;

  assign w_coef_a  = s_axis_data[COEF_A_LSB +: COEF_PACK_W];
  assign w_coef_b  = s_axis_data[COEF_B_LSB +: COEF_PACK_W];
  assign w_accept  = s_axis_valid && s_axis_ready;
  assign w_load    = w_accept && (r_wcnt == LAST_WORD);
  assign w_consume = o_valid && i_ready;

  // Stall only the final word of a row while the previous row is still held
  assign s_axis_ready = !i_rst && !((r_wcnt == LAST_WORD) && w_full);

  // Sign-extend the held coefficients plus the word-3 pair into a full row
  always_comb begin
    w_row_data = '0;
    for (int i = 0; i < int'(COLS_PER_ROW) - 2; i++) begin
      w_row_data[i] = COEF_W'(signed'(r_hold[i]));
    end
    w_row_data[COLS_PER_ROW-2] = COEF_W'(signed'(w_coef_a));
    w_row_data[COLS_PER_ROW-1] = COEF_W'(signed'(w_coef_b));
  end

  // Word counter, holding register and row/plane position of the row being assembled
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wcnt  <= 2'd0;
      r_hold  <= '0;
      r_row   <= 3'd0;
      r_plane <= PLANE_Y;
    end else if (w_accept) begin
      case (r_wcnt)
        2'd0: begin r_hold[0] <= w_coef_a; r_hold[1] <= w_coef_b; end
        2'd1: begin r_hold[2] <= w_coef_a; r_hold[3] <= w_coef_b; end
        2'd2: begin r_hold[4] <= w_coef_a; r_hold[5] <= w_coef_b; end
        default: ;
      endcase
      if (r_wcnt == LAST_WORD) begin
        r_wcnt <= 2'd0;
        if (r_row == LAST_ROW) begin
          r_row   <= 3'd0;
          r_plane <= (r_plane == LAST_PLANE) ? PLANE_Y : r_plane + 2'd1;
        end else begin
          r_row <= r_row + 3'd1;
        end
      end else begin
        r_wcnt <= r_wcnt + 2'd1;
      end
    end
  end

  // Pulse once when the last row of the last plane leaves the block
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_intr <= 1'b0;
    else       r_intr <= w_consume && (o_plane == LAST_PLANE) && (o_row == LAST_ROW);
  end

  assign o_intr = r_intr;

`ifdef TAG_CHECK_EN
  tag_t w_tag;
  logic r_tag_err;

  assign w_tag = tag_t'(s_axis_data[TAG_LSB +: TAG_W]);

  // Sticky flag: any accepted word whose tag disagrees with the assembly position
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                                                   r_tag_err <= 1'b0;
    else if (w_accept && (w_tag != expected_tag(r_row, r_plane))) r_tag_err <= 1'b1;
  end

  assign o_tag_err = r_tag_err;
`else
  logic [TAG_W-1:0] w_unused_tag;
  assign w_unused_tag = s_axis_data[TAG_LSB +: TAG_W];
  assign o_tag_err    = 1'b0;
`endif

  coef_row_reg #(.COEF_W(COEF_W)) u_row_reg (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load  (w_load),
    .i_data  (w_row_data),
    .i_plane (r_plane),
    .i_row   (r_row),
    .i_ready (i_ready),
    .o_valid (o_valid),
    .o_data  (w_out_data),
    .o_plane (o_plane),
    .o_row   (o_row)
  );

  assign w_full  = o_valid;
  assign o_data0 = w_out_data[0];
  assign o_data1 = w_out_data[1];
  assign o_data2 = w_out_data[2];
  assign o_data3 = w_out_data[3];
  assign o_data4 = w_out_data[4];
  assign o_data5 = w_out_data[5];
  assign o_data6 = w_out_data[6];
  assign o_data7 = w_out_data[7];

endmodule

// File: tb/tb_coef_stream_unpacker.sv
// Scoreboard bench for coef_stream_unpacker (COEF_W=16). Tag checks are
// exercised when TAG_CHECK_EN is defined.
module tb_coef_stream_unpacker;

  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   s_data;
  logic          s_valid;
  logic          s_ready;
  logic [CW-1:0] d0, d1, d2, d3, d4, d5, d6, d7;
  logic [1:0]    plane;
  logic [2:0]    row;
  logic          o_valid;
  logic          i_ready = 1'b0;
  logic          intr;
  logic          tag_err;
  logic [CW-1:0] dout [8];

  coef_stream_unpacker #(.COEF_W(CW), .NUM_PLANES(3)) dut (
    .i_clk(clk), .i_rst(rst),
    .s_axis_data(s_data), .s_axis_valid(s_valid), .s_axis_ready(s_ready),
    .o_data0(d0), .o_data1(d1), .o_data2(d2), .o_data3(d3),
    .o_data4(d4), .o_data5(d5), .o_data6(d6), .o_data7(d7),
    .o_plane(plane), .o_row(row), .o_valid(o_valid), .i_ready(i_ready),
    .o_intr(intr), .o_tag_err(tag_err)
  );

  always #5 clk = ~clk;

  assign dout[0] = d0; assign dout[1] = d1; assign dout[2] = d2; assign dout[3] = d3;
  assign dout[4] = d4; assign dout[5] = d5; assign dout[6] = d6; assign dout[7] = d7;

  typedef struct { int d[8]; int plane; int row; } exp_t;

  exp_t          exp_q[$];
  exp_t          e;
  int            errors = 0;
  int            checks = 0;
  int            seq = 0;
  int            ready_ctl = 1;
  int            cyc = 0;
  int            last_hs = -1;
  bit            chk_spacing = 0;
  int            intr_cnt = 0;
  int            words_acc = 0;
  bit            exp_intr = 0;
  bit            prev_stall = 0;
  logic [CW-1:0] prev_d [8];
  logic [1:0]    prev_plane;
  logic [2:0]    prev_row;

  task automatic check(input bit ok, input string name, input int act, input int req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at t=%0t", name, act, act, req, req, $time);
    end
  endtask

  function automatic int sext12(input int v);
    return (v >= 2048) ? v - 4096 : v;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream ready: 0 = held low, 1 = held high, 2 = random
  always @(posedge clk) begin
    #1;
    case (ready_ctl)
      0:       i_ready = 1'b0;
      1:       i_ready = 1'b1;
      default: i_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: pops the scoreboard on every row handshake
  always @(negedge clk) begin
    if (rst) begin
      exp_intr   = 0;
      prev_stall = 0;
      last_hs    = -1;
    end else begin
      if (exp_intr || intr) check(intr == exp_intr, "o_intr", int'(intr), int'(exp_intr));
      if (intr) intr_cnt++;
      exp_intr = 0;
      if (prev_stall) begin
        bit st;
        st = o_valid && (plane == prev_plane) && (row == prev_row);
        for (int i = 0; i < 8; i++) if (dout[i] !== prev_d[i]) st = 0;
        check(st, "hold_stable", int'(row), int'(prev_row));
      end
      prev_stall = o_valid && !i_ready;
      for (int i = 0; i < 8; i++) prev_d[i] = dout[i];
      prev_plane = plane;
      prev_row   = row;
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          check(0, "unexpected_row", int'(row), -1);
        end else begin
          int bad;
          e   = exp_q.pop_front();
          bad = -1;
          for (int i = 7; i >= 0; i--) if (dout[i] !== CW'(e.d[i])) bad = i;
          if (bad >= 0) check(0, $sformatf("row_data col%0d", bad), int'(dout[bad]), int'(CW'(e.d[bad])));
          else          check(1, "row_data", 0, 0);
          check(plane == 2'(e.plane) && row == 3'(e.row), "plane_row",
                int'(plane) * 8 + int'(row), e.plane * 8 + e.row);
          if (e.plane == 2 && e.row == 7) exp_intr = 1;
        end
        if (chk_spacing && last_hs >= 0) check(cyc - last_hs == 4, "row_spacing", cyc - last_hs, 4);
        last_hs = cyc;
      end
    end
  end

  task automatic send_word(input logic [31:0] w, input bit rnd_gap);
    int n;
    if (rnd_gap) begin
      s_valid = 1'b0;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    s_data  = w;
    s_valid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!s_ready && n < 300);
    if (!s_ready) check(0, "word_accept_timeout", n, 300);
    @(posedge clk); #1;
    s_valid = 1'b0;
    words_acc++;
  endtask

  task automatic send_row(input int c[8], input bit rnd_gap, input bit rnd_tag,
                          input int bad_word, input bit chk_lat);
    int          p, r;
    exp_t        x;
    logic [7:0]  tag;
    p = (seq / 8) % 3;
    r = seq % 8;
    seq++;
    for (int i = 0; i < 8; i++) x.d[i] = sext12(c[i]);
    x.plane = p;
    x.row   = r;
    exp_q.push_back(x);
    for (int k = 0; k < 4; k++) begin
      tag = {3'b000, 3'(r), 2'(p)};
      if (rnd_tag) tag = 8'($urandom);
      if (k == bad_word) begin
        tag = {3'b000, 3'd3, 2'(p)};
        check(tag_err == 1'b0, "tag_err_before", int'(tag_err), 0);
      end
      send_word({tag, 12'(c[2*k+1]), 12'(c[2*k])}, rnd_gap);
      if (k == bad_word) check(tag_err == 1'b1, "tag_err_rise", int'(tag_err), 1);
    end
    if (chk_lat) check(o_valid && row == 3'(r) && plane == 2'(p), "latency", int'(o_valid), 1);
  endtask

  task automatic apply_reset();
    s_valid = 1'b0;
    rst     = 1'b1;
    exp_q.delete();
    seq = 0;
    @(negedge clk);
    check(s_ready == 1'b0, "rst_s_ready", int'(s_ready), 0);
    check(o_valid == 1'b0 && intr == 1'b0 && tag_err == 1'b0, "rst_flags",
          int'({o_valid, intr, tag_err}), 0);
    check({d0, d1, d2, d3, d4, d5, d6, d7, plane, row} == '0, "rst_data", int'(d0), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check(s_ready == 1'b1, "post_rst_s_ready", int'(s_ready), 1);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin @(posedge clk); n++; end
    if (exp_q.size() != 0) check(0, "drain_timeout", exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $finish;
  end

  initial begin
    int c[8];
    int base;
    bit rnd_tag;
    rst     = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;

    // Reset and a full in-order macroblock at full rate
    ready_ctl = 1;
    apply_reset();
    chk_spacing = 1;
    for (int i = 0; i < 8; i++) c[i] = i;
    for (int r = 0; r < 24; r++) send_row(c, 0, 0, -1, 1);
    drain();
    chk_spacing = 0;
    check(intr_cnt == 1, "intr_count_block", intr_cnt, 1);

    // Downstream stall while the next row completes
    ready_ctl = 0;
    for (int i = 0; i < 8; i++) c[i] = int'($urandom_range(0, 4095));
    send_row(c, 0, 0, -1, 0);
    base = words_acc;
    fork
      begin
        int c2[8];
        for (int i = 0; i < 8; i++) c2[i] = int'($urandom_range(0, 4095));
        send_row(c2, 0, 0, -1, 0);
      end
      begin
        int n = 0;
        do begin @(negedge clk); n++; end while (!(s_valid && !s_ready) && n < 100);
        check(!s_ready && o_valid, "stall_ready_low", int'(s_ready), 0);
        check(words_acc == base + 3, "stall_at_word3", words_acc - base, 3);
        repeat (3) @(negedge clk);
        check(!s_ready, "stall_ready_held", int'(s_ready), 0);
        ready_ctl = 1;
        @(negedge clk);
        check(!s_ready, "stall_bubble", int'(s_ready), 0);
        @(negedge clk);
        check(s_ready, "stall_ready_return", int'(s_ready), 1);
      end
    join
    drain();

    // Reset in the middle of a row, then a fresh macroblock with extreme values
    send_word(32'h0000_5A5A, 0);
    send_word(32'h0000_A5A5, 0);
    apply_reset();
    base = intr_cnt;
    for (int i = 0; i < 8; i++) c[i] = int'($urandom_range(0, 4095));
    c[0] = 'h800;
    c[1] = 'h7FF;
    send_row(c, 0, 0, -1, 1);
    check(d0 === 16'hF800, "sext_neg", int'(d0), 'hF800);
    check(d1 === 16'h07FF, "sext_pos", int'(d1), 'h07FF);
    for (int r = 1; r < 24; r++) begin
      for (int i = 0; i < 8; i++) c[i] = int'($urandom_range(0, 4095));
      send_row(c, 0, 0, -1, 0);
    end
    drain();
    check(intr_cnt - base == 1, "intr_count_after_rst", intr_cnt - base, 1);

    // Randomised valid/ready over 10 macroblocks
`ifdef TAG_CHECK_EN
    rnd_tag = 0;
`else
    rnd_tag = 1;
`endif
    apply_reset();
    base = intr_cnt;
    ready_ctl = 2;
    for (int r = 0; r < 240; r++) begin
      for (int i = 0; i < 8; i++) c[i] = int'($urandom_range(0, 4095));
      send_row(c, 1, rnd_tag, -1, 0);
    end
    drain();
    check(intr_cnt - base == 10, "intr_count_random", intr_cnt - base, 10);

`ifdef TAG_CHECK_EN
    // Corrupted tag on stream word 5; data must still flow unchanged
    ready_ctl = 1;
    apply_reset();
    for (int r = 0; r < 24; r++) begin
      for (int i = 0; i < 8; i++) c[i] = int'($urandom_range(0, 4095));
      send_row(c, 0, 0, (r == 1) ? 1 : -1, 0);
    end
    drain();
    check(tag_err == 1'b1, "tag_err_sticky", int'(tag_err), 1);
`else
    check(tag_err == 1'b0, "tag_err_tied", int'(tag_err), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
